// File: rtl/snn_bus_sram_responder.sv
// Bus slave fronting a word-organised SRAM window, with configurable wait states,
// byte strobes, out-of-range error responses and a priority DMA sideband read port.
module snn_bus_sram_responder #(
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
   parameter int          DEPTH_WORDS = 256,
   parameter int          WAIT_CYCLES = 0
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           s_valid,
   input  logic                           s_write,
   input  logic [31:0]                    s_addr,
   input  logic [31:0]                    s_wdata,
   input  logic [3:0]                     s_wstrb,
   output logic                           s_ready,
   output logic                           s_rvalid,
   output logic [31:0]                    s_rdata,
   output logic                           s_err,
   input  logic                           dma_rd_en,
   input  logic [$clog2(DEPTH_WORDS)-1:0] dma_rd_addr,
   output logic [31:0]                    dma_rd_data,
   output logic [15:0]                    access_count,
   output logic [7:0]                     err_count
);

   localparam int AW = $clog2(DEPTH_WORDS);

   typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_EXEC, ST_REARM} state_t;

   state_t         state, state_nxt;
   logic           armed;
   logic [3:0]     cnt, cnt_nxt;
   logic           op_write, op_hit;
   logic [AW-1:0]  op_index;
   logic [31:0]    op_wdata;
   logic [3:0]     op_wstrb;

   logic [31:0]    mem [DEPTH_WORDS];

   logic [31:0]    offset;
   logic           req_hit;
   logic [AW-1:0]  req_index;
   logic           unused_offset_bits;

   logic           accept, fire, perform;
   logic           cur_write, cur_hit;
   logic [AW-1:0]  cur_index;
   logic [31:0]    cur_wdata;
   logic [3:0]     cur_wstrb;

   assign offset             = s_addr - BASE_ADDR;
   assign req_hit            = offset[31:2] < 30'(DEPTH_WORDS);
   assign req_index          = offset[AW+1:2];
   assign unused_offset_bits = ^offset[1:0];

   // With no wait states the op executes on the acceptance edge itself, so the
   // request is taken straight from the bus rather than from the capture registers.
   always_comb begin
      cur_write = op_write;
      cur_hit   = op_hit;
      cur_index = op_index;
      cur_wdata = op_wdata;
      cur_wstrb = op_wstrb;
      if (state == ST_IDLE) begin
         cur_write = s_write;
         cur_hit   = req_hit;
         cur_index = req_index;
         cur_wdata = s_wdata;
         cur_wstrb = s_wstrb;
      end
   end

   assign accept  = (state == ST_IDLE) && s_valid && armed;
   assign fire    = (accept && (WAIT_CYCLES == 0)) ||
                    ((state == ST_WAIT) && (cnt == 4'd1)) ||
                    (state == ST_EXEC);
   assign perform = fire && !dma_rd_en;

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      case (state)
         ST_IDLE: begin
            if (accept) begin
               if (WAIT_CYCLES == 0) begin
                  state_nxt = perform ? ST_REARM : ST_EXEC;
               end else begin
                  state_nxt = ST_WAIT;
                  cnt_nxt   = 4'(WAIT_CYCLES);
               end
            end
         end
         ST_WAIT: begin
            cnt_nxt = cnt - 4'd1;
            if (cnt == 4'd1) state_nxt = perform ? ST_REARM : ST_EXEC;
         end
         ST_EXEC: begin
            if (perform) state_nxt = ST_REARM;
         end
         ST_REARM: begin
            if (!s_valid) state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= ST_IDLE;
         armed        <= 1'b1;
         cnt          <= 4'd0;
         op_write     <= 1'b0;
         op_hit       <= 1'b0;
         op_index     <= '0;
         op_wdata     <= 32'd0;
         op_wstrb     <= 4'd0;
         s_ready      <= 1'b0;
         s_rvalid     <= 1'b0;
         s_err        <= 1'b0;
         s_rdata      <= 32'd0;
         dma_rd_data  <= 32'd0;
         access_count <= 16'd0;
         err_count    <= 8'd0;
      end else begin
         state    <= state_nxt;
         cnt      <= cnt_nxt;
         s_ready  <= 1'b0;
         s_rvalid <= 1'b0;
         s_err    <= 1'b0;
         if (accept) begin
            op_write <= s_write;
            op_hit   <= req_hit;
            op_index <= req_index;
            op_wdata <= s_wdata;
            op_wstrb <= s_wstrb;
         end
         if (perform) begin
            s_ready      <= 1'b1;
            s_rvalid     <= ~cur_write;
            s_err        <= ~cur_hit;
            armed        <= 1'b0;
            access_count <= access_count + 16'd1;
            if (!cur_write) s_rdata <= cur_hit ? mem[cur_index] : 32'd0;
            if (!cur_hit && (err_count != 8'hFF)) err_count <= err_count + 8'd1;
         end
         if ((state == ST_REARM) && !s_valid) armed <= 1'b1;
         // DMA reads see pre-write contents because a colliding bus op is deferred.
         if (dma_rd_en) dma_rd_data <= mem[dma_rd_addr];
      end
   end

   always_ff @(posedge clk) begin
      if (!rst && perform && cur_write && cur_hit) begin
         for (int b = 0; b < 4; b++) begin
            if (cur_wstrb[b]) mem[cur_index][8*b +: 8] <= cur_wdata[8*b +: 8];
         end
      end
   end

endmodule

// File: tb/tb_snn_bus_sram_responder.sv
// Scoreboard bench for snn_bus_sram_responder: instance a (no wait states, offset base)
// and instance b (three wait states) share request lines but have separate valid/reset.
module tb_snn_bus_sram_responder;

   localparam logic [31:0] BASE_A = 32'h1000_0400;
   localparam logic [31:0] BASE_B = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        rst_a, rst_b, va, vb;
   logic        s_write;
   logic [31:0] s_addr, s_wdata;
   logic [3:0]  s_wstrb;
   logic        dma_rd_en;
   logic [7:0]  dma_rd_addr;

   logic        a_ready, a_rvalid, a_err, b_ready, b_rvalid, b_err;
   logic [31:0] a_rdata, b_rdata, a_dma, b_dma;
   logic [15:0] a_acc, b_acc;
   logic [7:0]  a_errc, b_errc;

   logic        sel = 1'b0;
   logic        m_ready, m_rvalid, m_err;
   logic [31:0] m_rdata, m_dma;
   logic [15:0] m_acc;
   logic [7:0]  m_errc;

   assign m_ready  = sel ? b_ready  : a_ready;
   assign m_rvalid = sel ? b_rvalid : a_rvalid;
   assign m_err    = sel ? b_err    : a_err;
   assign m_rdata  = sel ? b_rdata  : a_rdata;
   assign m_dma    = sel ? b_dma    : a_dma;
   assign m_acc    = sel ? b_acc    : a_acc;
   assign m_errc   = sel ? b_errc   : a_errc;

   always #5 clk = ~clk;

   snn_bus_sram_responder #(.BASE_ADDR(BASE_A), .DEPTH_WORDS(256), .WAIT_CYCLES(0)) dut_a (
      .clk(clk), .rst(rst_a), .s_valid(va), .s_write(s_write), .s_addr(s_addr),
      .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_ready(a_ready), .s_rvalid(a_rvalid),
      .s_rdata(a_rdata), .s_err(a_err), .dma_rd_en(dma_rd_en), .dma_rd_addr(dma_rd_addr),
      .dma_rd_data(a_dma), .access_count(a_acc), .err_count(a_errc));

   snn_bus_sram_responder #(.BASE_ADDR(BASE_B), .DEPTH_WORDS(256), .WAIT_CYCLES(3)) dut_b (
      .clk(clk), .rst(rst_b), .s_valid(vb), .s_write(s_write), .s_addr(s_addr),
      .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_ready(b_ready), .s_rvalid(b_rvalid),
      .s_rdata(b_rdata), .s_err(b_err), .dma_rd_en(dma_rd_en), .dma_rd_addr(dma_rd_addr),
      .dma_rd_data(b_dma), .access_count(b_acc), .err_count(b_errc));

   typedef struct {
      logic [31:0] rdata;
      logic        rvalid;
      logic        err;
      int          lat;
   } resp_t;

   resp_t       sbq[$];
   logic [31:0] model [2][256];
   int          acc_exp [2];
   int          errc_exp [2];
   logic [31:0] last_rdata;
   int          n_checks = 0;
   int          n_errors = 0;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   task automatic set_valid(input bit which, input logic v);
      if (which) vb = v;
      else       va = v;
   endtask

   // One bus access; defer > 0 holds a same-word DMA read for that many cycles.
   task automatic access(input bit which, input bit wr, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [3:0] st, input int hold,
                         input int defer);
      logic [31:0] base, off, old;
      logic [7:0]  idx;
      bit          hit;
      resp_t       e, r;
      int          pulses, last_cyc;
      base   = which ? BASE_B : BASE_A;
      off    = addr - base;
      idx    = off[9:2];
      hit    = off[31:10] == 22'd0;
      old    = model[which][idx];
      e.rvalid = !wr;
      e.err    = !hit;
      e.rdata  = (!wr && hit) ? old : 32'd0;
      e.lat    = (which ? 3 : 0) + 1 + defer;
      if (wr && hit) begin
         for (int b = 0; b < 4; b++)
            if (st[b]) model[which][idx][8*b +: 8] = wd[8*b +: 8];
      end
      sbq.push_back(e);
      acc_exp[which]++;
      if (!hit && errc_exp[which] < 255) errc_exp[which]++;

      sel     = which;
      s_write = wr;
      s_addr  = addr;
      s_wdata = wd;
      s_wstrb = st;
      set_valid(which, 1'b1);
      if (defer > 0) begin
         dma_rd_en   = 1'b1;
         dma_rd_addr = idx;
      end
      pulses   = 0;
      last_cyc = (hold + 1 > e.lat + 1) ? hold + 1 : e.lat + 1;
      for (int cyc = 1; cyc <= last_cyc; cyc++) begin
         @(negedge clk);
         if (cyc == hold) set_valid(which, 1'b0);
         if (cyc <= defer) chk("dma_old", m_dma, old);
         if (cyc == defer) dma_rd_en = 1'b0;
         if (m_ready) begin
            pulses++;
            if (sbq.size() > 0) begin
               r = sbq.pop_front();
               chk("rvalid", 32'(m_rvalid), 32'(r.rvalid));
               chk("err", 32'(m_err), 32'(r.err));
               chk("latency", 32'(cyc), 32'(r.lat));
               if (r.rvalid) chk("rdata", m_rdata, r.rdata);
               last_rdata = m_rdata;
            end
         end
      end
      chk("ready_pulses", 32'(pulses), 32'd1);
   endtask

   task automatic chk_counters(input bit which);
      sel = which;
      #0;
      chk("access_count", 32'(m_acc), 32'(acc_exp[which]));
      chk("err_count", 32'(m_errc), 32'(errc_exp[which]));
   endtask

   task automatic dma_read(input bit which, input logic [7:0] idx, input logic [31:0] exp);
      sel         = which;
      dma_rd_en   = 1'b1;
      dma_rd_addr = idx;
      @(negedge clk);
      dma_rd_en = 1'b0;
      chk("dma_read", m_dma, exp);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int seen;
      acc_exp  = '{0, 0};
      errc_exp = '{0, 0};
      rst_a = 1'b1; rst_b = 1'b1; va = 1'b0; vb = 1'b0;
      s_write = 1'b0; s_addr = 32'd0; s_wdata = 32'd0; s_wstrb = 4'd0;
      dma_rd_en = 1'b0; dma_rd_addr = 8'd0;
      repeat (3) @(negedge clk);
      chk("rst_ready", 32'(a_ready), 32'd0);
      chk("rst_rvalid", 32'(a_rvalid), 32'd0);
      chk("rst_err", 32'(a_err), 32'd0);
      chk("rst_rdata", a_rdata, 32'd0);
      chk("rst_dma", a_dma, 32'd0);
      chk("rst_acc_b", 32'(b_acc), 32'd0);
      chk_counters(0);
      rst_a = 1'b0; rst_b = 1'b0;
      @(negedge clk);

      // Basic write then read with valid held two cycles
      access(0, 1, BASE_A, 32'h0000_00FF, 4'hF, 1, 0);
      access(0, 0, BASE_A, 32'd0, 4'h0, 2, 0);
      chk("basic_rdata", last_rdata, 32'h0000_00FF);
      chk_counters(0);

      // Byte strobes
      access(0, 1, BASE_A + 12, 32'hAABB_CCDD, 4'hF, 1, 0);
      access(0, 1, BASE_A + 12, 32'h1122_3344, 4'b0101, 1, 0);
      access(0, 0, BASE_A + 12, 32'd0, 4'h0, 1, 0);
      chk("strb_rdata", last_rdata, 32'hAA22_CC44);

      // Valid held four cycles gives one access; next request after one low cycle
      access(0, 1, BASE_A + 28, 32'h0000_0077, 4'hF, 4, 0);
      chk_counters(0);
      access(0, 0, BASE_A + 28, 32'd0, 4'h0, 1, 0);
      chk("rearm_rdata", last_rdata, 32'h0000_0077);

      // Out of range read and write
      access(0, 0, BASE_A + 1024, 32'd0, 4'h0, 1, 0);
      chk("oor_rdata", last_rdata, 32'd0);
      chk_counters(0);
      access(0, 1, BASE_A + 1024, 32'hDEAD_BEEF, 4'hF, 1, 0);
      access(0, 1, BASE_A - 4, 32'hDEAD_BEEF, 4'hF, 1, 0);
      chk_counters(0);
      access(0, 0, BASE_A, 32'd0, 4'h0, 1, 0);
      chk("miss_word0", last_rdata, 32'h0000_00FF);
      access(0, 0, BASE_A + 1020, 32'd0, 4'h0, 1, 0);

      // DMA collision defers the bus write by three cycles
      access(0, 1, BASE_A + 20, 32'd0, 4'hF, 1, 0);
      access(0, 1, BASE_A + 20, 32'h1234_5678, 4'hF, 1, 3);
      dma_read(0, 8'd5, 32'h1234_5678);

      // Zero-strobe write completes without changing memory
      access(0, 1, BASE_A + 12, 32'hFFFF_FFFF, 4'h0, 1, 0);
      access(0, 0, BASE_A + 12, 32'd0, 4'h0, 1, 0);
      chk("wstrb0_rdata", last_rdata, 32'hAA22_CC44);
      chk_counters(0);

      // Wait-state instance: reset during WAIT aborts a pending write
      access(1, 1, BASE_B + 32, 32'h5555_AAAA, 4'hF, 1, 0);
      chk_counters(1);
      sel = 1'b1;
      s_write = 1'b1; s_addr = BASE_B + 32; s_wdata = 32'h0BAD_0BAD; s_wstrb = 4'hF;
      vb = 1'b1;
      @(negedge clk);
      vb = 1'b0;
      rst_b = 1'b1;
      @(negedge clk);
      rst_b = 1'b0;
      seen = 0;
      repeat (6) begin
         @(negedge clk);
         if (b_ready) seen++;
      end
      chk("abort_no_ready", 32'(seen), 32'd0);
      acc_exp[1]  = 0;
      errc_exp[1] = 0;
      chk_counters(1);
      access(1, 0, BASE_B + 32, 32'd0, 4'h0, 1, 0);
      chk("abort_word", last_rdata, 32'h5555_AAAA);
      access(1, 1, BASE_B + 36, 32'hCAFE_F00D, 4'hF, 1, 0);
      access(1, 0, BASE_B + 36, 32'd0, 4'h0, 1, 0);
      chk_counters(1);

      chk("scoreboard_empty", 32'(sbq.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/snn_bus_sram_responder.md
Name: snn_bus_sram_responder

Overview:
- Bus responder (slave) for the SoC master bus (valid/write/addr/wdata/wstrb out; ready/rvalid/rdata back).
- Fronts a word-organised data SRAM window, for example the input-pattern buffer written by software and later read by DMA.
- Adds a DMA sideband read port that has priority over the bus.
- Supports configurable wait states, byte strobes, out-of-range error signalling, and a one-access-per-request re-arm rule for masters that hold valid for more than one cycle.

Parameters:
- BASE_ADDR, 32'h0000_0000, byte address of word 0.
- DEPTH_WORDS, 256, number of 32-bit words (power of two, 2..4096).
- WAIT_CYCLES, 0, extra cycles between acceptance and execution (0..15).

Ports:
- clk  input  1  clock; all logic on posedge.
- rst  input  1  synchronous active-high reset.
- s_valid  input  1  master request valid.
- s_write  input  1  1 = write, 0 = read.
- s_addr  input  32  byte address; bits [1:0] ignored.
- s_wdata  input  32  write data.
- s_wstrb  input  4  byte enables; bit k enables byte k.
- s_ready  output  1  one-cycle pulse: access completed.
- s_rvalid  output  1  one-cycle pulse with s_ready on reads.
- s_rdata  output  32  read data; holds until next read response.
- s_err  output  1  one-cycle pulse with s_ready on an out-of-range access.
- dma_rd_en  input  1  sideband read request.
- dma_rd_addr  input  $clog2(DEPTH_WORDS)  sideband word index.
- dma_rd_data  output  32  sideband data, valid the cycle after dma_rd_en.
- access_count  output  16  completed bus accesses; wraps.
- err_count  output  8  out-of-range accesses; saturates at 255.

Behaviour:
- Reset (clk edge with rst = 1):
  - State goes to IDLE with armed = 1.
  - s_ready, s_rvalid, s_err, s_rdata, dma_rd_data, access_count and err_count all go to 0.
  - The SRAM array is not reset.
  - Reset mid-access aborts the access: no write is committed and no response is issued.
- Decode:
  - offset = s_addr - BASE_ADDR, 32-bit modulo.
  - Hit if offset[31:2] < DEPTH_WORDS; index = offset[31:2].
- State machine: IDLE, WAIT, EXEC, REARM.
- IDLE:
  - If s_valid and armed: capture write/index/hit/wdata/wstrb at edge N.
  - If WAIT_CYCLES = 0, go straight to EXEC behaviour in the same edge.
  - Otherwise load the wait counter with WAIT_CYCLES and go to WAIT.
- WAIT: decrement the counter each edge; go to EXEC when it reaches 0.
- EXEC:
  - If dma_rd_en = 1 at this edge, the DMA read is serviced and the bus op is deferred; stay in EXEC.
  - Deferral repeats for every consecutive cycle that dma_rd_en is 1.
  - Otherwise perform the op:
    - Write hit: update enabled bytes only.
    - Read hit: s_rdata <= mem[index].
    - Miss: no memory change, s_rdata <= 0 on read, s_err <= 1.
  - Also at this edge: s_ready <= 1, s_rvalid <= ~write, access_count += 1, err_count += miss (saturating). Go to REARM.
- Latency:
  - WAIT_CYCLES = 0 with no collision: s_ready is high in the cycle immediately after acceptance edge N.
  - In general s_ready is high after edge N + WAIT_CYCLES + deferrals.
- Response pulses: s_ready, s_rvalid and s_err are 1 for exactly one cycle, then return to 0.
- REARM:
  - armed = 0. The block returns to IDLE only after sampling s_valid = 0.
  - A master holding valid across the response gets exactly one access.
  - A new request is accepted no earlier than the edge after valid is first seen low.
- DMA port:
  - dma_rd_data <= mem[dma_rd_addr] on any edge with dma_rd_en, in any state.
  - It holds otherwise.
  - Same-address collision with a pending bus write: DMA reads the old data; the write commits afterwards.
- Requests presented while the FSM is not in IDLE are ignored: s_valid is a level, not queued.
- Wstrb = 0 write: completes normally (ready, counted) with no memory change.

Test Plan:
- WAIT_CYCLES = 0: write 0x0000_00FF to BASE_ADDR, then read it with valid held 2 cycles → s_ready high the cycle after acceptance, s_rvalid = 1, s_rdata = 0x0000_00FF, access_count = 2.
- Strobes: write 0xAABB_CCDD with wstrb F, then 0x1122_3344 with wstrb 4'b0101 to word 3 → read returns 0xAA22_CC44.
- Re-arm: s_valid held high 4 cycles → exactly one ready pulse and access_count += 1. A back-to-back request after one low cycle is accepted and completes.
- Out of range: read at BASE_ADDR + DEPTH_WORDS*4 → s_ready, s_rvalid and s_err pulse together, s_rdata = 0, err_count = 1. A following miss write leaves all words unchanged.
- Collision: bus write 0x1234_5678 to word 5 (old 0) reaches EXEC while dma_rd_en addresses word 5 for 3 cycles → dma_rd_data = 0 each cycle, s_ready delayed exactly 3 cycles, next DMA read returns 0x1234_5678.
- WAIT_CYCLES = 3 instance: accept a write, assert rst for 1 cycle during WAIT → no s_ready, word unchanged, counters 0. A fresh write/read after reset completes with ready 4 cycles after acceptance.
